// File: rtl/pci_pkg.sv
// Shared PCI definitions: arbiter states, active-low levels,
// and the bus command codes decoded by the targets.
package pci_pkg;

    typedef enum logic [1:0] {
        ARB_GAP   = 2'd0,
        ARB_PARK  = 2'd1,
        ARB_GRANT = 2'd2
    } arb_state_e;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    localparam logic [3:0] CMD_MEM_READ      = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE     = 4'b0111;
    localparam logic [3:0] CMD_MEM_READ_MULT = 4'b1100;
    localparam logic [3:0] CMD_MEM_READ_LINE = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV = 4'b1111;

endpackage

// File: rtl/pci_rr_picker.sv
// Rotating priority encoder: first eligible request found
// searching cyclically from ptr+1 to ptr+N_MASTERS.
module pci_rr_picker #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_vec,
    input  logic [IDX_W-1:0]     ptr,
    input  logic [N_MASTERS-1:0] mask,
    output logic [IDX_W-1:0]     winner,
    output logic                 any_req
);

    logic [N_MASTERS-1:0] eligible;

    assign eligible = req_vec & ~mask;

    // Scan farthest-first so the nearest eligible index wins last
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            if (eligible[IDX_W'((int'(ptr) + i) % N_MASTERS)]) begin
                winner  = IDX_W'((int'(ptr) + i) % N_MASTERS);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with idle turnaround and parking.
// Optional grant timeout: define PCI_ARB_TIMEOUT_EN.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int IDX_W       = $clog2(N_MASTERS),
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 CLK,
    input  logic                 REST,
    input  logic [N_MASTERS-1:0] REQ,
    output logic [N_MASTERS-1:0] GNT,
    input  logic                 FRAME,
    input  logic                 IRDY,
    output logic [IDX_W-1:0]     OWNER,
    output logic                 OWNER_VALID,
    output logic                 BUS_IDLE
);

    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    arb_state_e           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 valid_q, valid_d;
    logic                 started_q, started_d;
    logic                 idle_q;

    logic                 idle;
    logic [N_MASTERS-1:0] req_act;
    logic [N_MASTERS-1:0] own_mask, ptr_mask, pick_mask;
    logic [IDX_W-1:0]     pick_ptr, winner;
    logic                 any_req, own_req, other_req, rearb;
    logic                 go_gap, go_park, go_win;
    logic                 tmo_fire, skip_q;

    assign idle    = FRAME & IRDY;
    assign req_act = ~REQ;

    // In GRANT the search starts after the current owner
    assign pick_ptr = (state_q == ARB_GRANT) ? owner_q : rr_ptr_q;

    // One-hot views of the owner and of the search origin
    always_comb begin
        own_mask           = '0;
        own_mask[owner_q]  = 1'b1;
        ptr_mask           = '0;
        ptr_mask[pick_ptr] = 1'b1;
    end

    assign pick_mask = (tmo_fire || skip_q) ? ptr_mask : '0;
    assign own_req   = |(req_act & own_mask);
    assign other_req = |(req_act & ~own_mask);
    assign rearb     = (started_q && other_req) || !own_req || tmo_fire;

    pci_rr_picker #(
        .N_MASTERS(N_MASTERS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req_vec(req_act),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .winner (winner),
        .any_req(any_req)
    );

    // Next-state, grant vector and owner bookkeeping
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        valid_d   = valid_q;
        rr_ptr_d  = rr_ptr_q;
        started_d = started_q;
        go_gap    = 1'b0;
        go_park   = 1'b0;
        go_win    = 1'b0;
        unique case (state_q)
            ARB_GAP: begin
                go_win  = any_req;
                go_park = !any_req;
            end
            ARB_PARK: begin
                started_d = 1'b0;
                if (any_req) begin
                    if (winner == PARK_IDX) state_d = ARB_GRANT;
                    else if (idle)          go_gap  = 1'b1;
                    else                    go_win  = 1'b1;
                end
            end
            ARB_GRANT: begin
                started_d = started_q | (FRAME == ASSERTED);
                if (rearb) begin
                    rr_ptr_d = owner_q;
                    go_gap   = idle;
                    go_win   = !idle && any_req;
                    go_park  = !idle && !any_req;
                end
            end
            default: go_gap = 1'b1;
        endcase
        if (go_gap) begin
            state_d   = ARB_GAP;
            gnt_d     = {N_MASTERS{DEASSERTED}};
            valid_d   = 1'b0;
            started_d = 1'b0;
        end else if (go_park) begin
            state_d         = ARB_PARK;
            gnt_d           = {N_MASTERS{DEASSERTED}};
            gnt_d[PARK_IDX] = ASSERTED;
            owner_d         = PARK_IDX;
            valid_d         = 1'b1;
            started_d       = 1'b0;
        end else if (go_win) begin
            state_d       = ARB_GRANT;
            gnt_d         = {N_MASTERS{DEASSERTED}};
            gnt_d[winner] = ASSERTED;
            owner_d       = winner;
            valid_d       = 1'b1;
            started_d     = 1'b0;
        end
    end

`ifdef PCI_ARB_TIMEOUT_EN
    logic [4:0] tmo_q, tmo_d;
    logic       tmo_run;

    assign tmo_run  = (state_q == ARB_GRANT) && !started_q && idle;
    assign tmo_fire = tmo_run && (tmo_q == 5'(TIMEOUT_CYC - 1));

    // Idle clocks spent by a granted master that has not started
    always_comb begin
        tmo_d = tmo_q;
        if ((state_q != ARB_GRANT) || (gnt_d != gnt_q)) tmo_d = '0;
        else if (tmo_run) tmo_d = tmo_q + 5'd1;
    end

    // Timeout counter and one-decision skip of the timed-out master
    always_ff @(posedge CLK) begin
        if (REST) begin
            tmo_q  <= '0;
            skip_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            skip_q <= tmo_fire;
        end
    end
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign tmo_fire = 1'b0;
    assign skip_q   = 1'b0;
`endif

    // Arbiter state and registered bus outputs
    always_ff @(posedge CLK) begin
        if (REST) begin
            state_q   <= ARB_GAP;
            gnt_q     <= {N_MASTERS{DEASSERTED}};
            owner_q   <= '0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= LAST_IDX;
            started_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
            started_q <= started_d;
            idle_q    <= idle;
        end
    end

    assign GNT         = gnt_q;
    assign OWNER       = owner_q;
    assign OWNER_VALID = valid_q;
    assign BUS_IDLE    = idle_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios plus random
// traffic against a rule-level model of the arbitration.
module tb_pci_bus_arbiter;

    localparam int N    = 4;
    localparam int PARK = 0;
    localparam int TMO  = 16;

    logic       CLK = 1'b0;
    logic       REST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       FRAME;
    logic       IRDY;
    logic [1:0] OWNER;
    logic       OWNER_VALID;
    logic       BUS_IDLE;

    int checks = 0;
    int passed = 0;

    // Model: holder -1 = nobody granted (turnaround), else index
    int m_hold, m_ptr, m_tmo, m_skip;
    bit m_park, m_started, m_idle;

    pci_bus_arbiter dut (
        .CLK        (CLK),
        .REST       (REST),
        .REQ        (REQ),
        .GNT        (GNT),
        .FRAME      (FRAME),
        .IRDY       (IRDY),
        .OWNER      (OWNER),
        .OWNER_VALID(OWNER_VALID),
        .BUS_IDLE   (BUS_IDLE)
    );

    always #5 CLK = ~CLK;

    function automatic int pick(int from, int skip);
        for (int k = 1; k <= N; k++)
            if (!REQ[(from + k) % N] && ((from + k) % N) != skip)
                return (from + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = '1;
        if (m_hold >= 0) g[m_hold] = 1'b0;
        return g;
    endfunction

    task automatic model_step();
        bit idle, fire, others, rearb;
        int w, o;
        idle = FRAME & IRDY;
        if (REST) begin
            m_hold = -1; m_park = 0; m_ptr = N - 1;
            m_started = 0; m_tmo = 0; m_skip = -1; m_idle = 1;
            return;
        end
        if (m_hold < 0) begin
            w = pick(m_ptr, m_skip);
            m_skip = -1;
            m_started = 0;
            if (w >= 0) begin m_hold = w; m_park = 0; end
            else begin m_hold = PARK; m_park = 1; end
        end else if (m_park) begin
            w = pick(m_ptr, -1);
            if (w == PARK) m_park = 0;
            else if (w >= 0) begin
                if (idle) m_hold = -1;
                else begin m_hold = w; m_park = 0; end
            end
        end else begin
            o = m_hold;
            fire = 0;
`ifdef PCI_ARB_TIMEOUT_EN
            if (!m_started && idle) begin
                m_tmo++;
                fire = (m_tmo == TMO);
            end
`endif
            others = 0;
            for (int k = 0; k < N; k++)
                if (k != o && !REQ[k]) others = 1;
            rearb = (m_started && others) || REQ[o] || fire;
            if (rearb) begin
                m_ptr = o;
                m_started = 0;
                m_tmo = 0;
                w = pick(o, -1);
                if (idle) begin
                    m_hold = -1;
                    if (fire) m_skip = o;
                end else if (w >= 0) m_hold = w;
                else begin m_hold = PARK; m_park = 1; end
            end else if (!FRAME) m_started = 1;
        end
        m_idle = idle;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        REST = 1; REQ = 4'b0000; FRAME = 0; IRDY = 0;
        tick(); tick();
        checks++;
        if (GNT !== 4'b1111) $display("FAIL reset_gnt got=%b want=1111", GNT);
        else passed++;
        checks++;
        if (OWNER !== 2'd0) $display("FAIL reset_owner got=%0d want=0", OWNER);
        else passed++;
        checks++;
        if (OWNER_VALID !== 1'b0) $display("FAIL reset_valid got=%b want=0", OWNER_VALID);
        else passed++;
        checks++;
        if (BUS_IDLE !== 1'b1) $display("FAIL reset_idle got=%b want=1", BUS_IDLE);
        else passed++;
        REQ = 4'b1111; FRAME = 1; IRDY = 1; REST = 0;
    endtask

    task automatic test_park();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (GNT !== 4'b1110 || GNT !== exp_gnt())
                $display("FAIL park_gnt c=%0d got=%b want=1110", c, GNT);
            else passed++;
            checks++;
            if (OWNER_VALID !== 1'b1) $display("FAIL park_valid c=%0d got=%b want=1", c, OWNER_VALID);
            else passed++;
        end
    endtask

    task automatic test_gap_grant();
        REQ = 4'b1011;
        tick();
        checks++;
        if (GNT !== 4'b1111) $display("FAIL gap_cycle got=%b want=1111", GNT);
        else passed++;
        tick();
        checks++;
        if (GNT !== 4'b1011 || OWNER !== 2'd2)
            $display("FAIL gap_grant got=%b/%0d want=1011/2", GNT, OWNER);
        else passed++;
    endtask

    task automatic test_hidden();
        int served[$];
        int got;
        FRAME = 0; IRDY = 0;
        tick();
        checks++;
        if (GNT !== 4'b1011) $display("FAIL hidden_hold got=%b want=1011", GNT);
        else passed++;
        REQ = 4'b0011;
        tick();
        checks++;
        if (GNT !== 4'b0111) $display("FAIL hidden_move got=%b want=0111", GNT);
        else passed++;
        FRAME = 1; IRDY = 0; REQ = 4'b0111;
        tick();
        FRAME = 0; IRDY = 0;
        tick();
        FRAME = 1; IRDY = 0; REQ = 4'b1000;
        tick();
        checks++;
        if (GNT !== 4'b1110) $display("FAIL hidden_to0 got=%b want=1110", GNT);
        else passed++;
        FRAME = 1; IRDY = 1;
        for (int c = 0; c < 30 && served.size() < 3; c++) begin
            if (OWNER_VALID && !REQ[OWNER]) begin
                served.push_back(int'(OWNER));
                REQ[OWNER] = 1'b1;
            end
            tick();
            checks++;
            if (GNT !== exp_gnt()) $display("FAIL serve_gnt c=%0d got=%b want=%b", c, GNT, exp_gnt());
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < served.size()) ? served[i] : -1;
            checks++;
            if (got != i) $display("FAIL serve_order i=%0d got=%0d want=%0d", i, got, i);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int ph, got;
        logic [3:0] prev;
        REST = 1; REQ = 4'b0000; FRAME = 1; IRDY = 1;
        tick();
        REST = 0; ph = 0; prev = 4'b1111;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            tick();
            checks++;
            if ($countones(~GNT) > 1 || GNT !== exp_gnt())
                $display("FAIL rr_gnt c=%0d got=%b want=%b", c, GNT, exp_gnt());
            else passed++;
            if (GNT != prev && GNT != 4'b1111) order.push_back(int'(OWNER));
            prev = GNT;
            case (ph)
                0: if (GNT != 4'b1111) begin FRAME = 0; IRDY = 0; ph = 1; end
                1: begin FRAME = 1; IRDY = 0; ph = 2; end
                default: begin FRAME = 1; IRDY = 1; ph = 0; end
            endcase
        end
        for (int i = 0; i < 5; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            checks++;
            if (got != i % 4) $display("FAIL rr_order i=%0d got=%0d want=%0d", i, got, i % 4);
            else passed++;
        end
        FRAME = 1; IRDY = 1;
    endtask

    task automatic test_timeout();
        int cnt;
        REST = 1; REQ = 4'b0101; FRAME = 1; IRDY = 1;
        tick();
        REST = 0;
        tick();
        checks++;
        if (GNT !== 4'b1101) $display("FAIL tmo_first got=%b want=1101", GNT);
        else passed++;
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (GNT !== exp_gnt()) $display("FAIL tmo_gnt i=%0d got=%b want=%b", i, GNT, exp_gnt());
            else passed++;
            if (GNT == 4'b1101) cnt++;
            else break;
        end
`ifdef PCI_ARB_TIMEOUT_EN
        checks++;
        if (cnt != TMO) $display("FAIL tmo_len got=%0d want=%0d", cnt, TMO);
        else passed++;
        checks++;
        if (GNT !== 4'b1111) $display("FAIL tmo_gap got=%b want=1111", GNT);
        else passed++;
        tick();
        checks++;
        if (GNT !== 4'b0111) $display("FAIL tmo_next got=%b want=0111", GNT);
        else passed++;
`else
        checks++;
        if (cnt != 101) $display("FAIL hold_len got=%0d want=101", cnt);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        REST = 1; REQ = 4'b1111; FRAME = 1; IRDY = 1;
        tick();
        REST = 0; REQ = 4'b1101;
        tick();
        FRAME = 0; IRDY = 0;
        tick();
        checks++;
        if (GNT !== 4'b1101) $display("FAIL rmid_pre got=%b want=1101", GNT);
        else passed++;
        REST = 1;
        tick();
        checks++;
        if (GNT !== 4'b1111 || OWNER_VALID !== 1'b0)
            $display("FAIL rmid_rst got=%b/%b want=1111/0", GNT, OWNER_VALID);
        else passed++;
        REST = 0; REQ = 4'b0000; FRAME = 1; IRDY = 1;
        tick();
        checks++;
        if (GNT !== 4'b1110 || OWNER !== 2'd0 || OWNER_VALID !== 1'b1)
            $display("FAIL rmid_first got=%b/%0d/%b want=1110/0/1", GNT, OWNER, OWNER_VALID);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0] prev;
        bit idle_e, rst_e, moved;
        REST = 1; REQ = 4'b1111; FRAME = 1; IRDY = 1;
        tick();
        REST = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) REQ[b] = ~REQ[b];
            FRAME = ($urandom_range(0, 3) != 0);
            IRDY  = ($urandom_range(0, 3) != 0);
            REST  = ($urandom_range(0, 199) == 0);
            prev = GNT; idle_e = FRAME & IRDY; rst_e = REST;
            tick();
            checks++;
            if (GNT !== exp_gnt()) $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, GNT, exp_gnt());
            else passed++;
            checks++;
            if (OWNER_VALID !== (m_hold >= 0))
                $display("FAIL rnd_valid c=%0d got=%b want=%b", c, OWNER_VALID, m_hold >= 0);
            else passed++;
            if (m_hold >= 0) begin
                checks++;
                if (OWNER !== 2'(m_hold)) $display("FAIL rnd_owner c=%0d got=%0d want=%0d", c, OWNER, m_hold);
                else passed++;
            end
            checks++;
            if (BUS_IDLE !== m_idle) $display("FAIL rnd_idle c=%0d got=%b want=%b", c, BUS_IDLE, m_idle);
            else passed++;
            moved = prev != 4'b1111 && GNT != 4'b1111 && GNT != prev;
            checks++;
            if ($countones(~GNT) > 1 || (moved && idle_e && !rst_e))
                $display("FAIL rnd_safe c=%0d got=%b prev=%b want=onehot,no idle move", c, GNT, prev);
            else passed++;
        end
        REST = 0;
    endtask

    initial begin
        REST = 1; REQ = 4'b1111; FRAME = 1; IRDY = 1;
        test_reset();
        test_park();
        test_gap_grant();
        test_hidden();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
